// File: rtl/bus_addr_if.sv
// bus_addr_if
// Bus-side signal group between the bus master and the address decoder.
//   addr   : 8-bit bus address driven by the master
//   req    : transfer-valid strobe driven by the master
//   s0_sel : slave 0 select returned by the decoder
//   s1_sel : slave 1 select returned by the decoder
// The master modport drives address/strobe; the slave modport (the decoder)
// drives the selects.
interface bus_addr_if;
  logic [7:0] addr;
  logic       req;
  logic       s0_sel;
  logic       s1_sel;

  modport master (
    output addr,
    output req,
    input  s0_sel,
    input  s1_sel
  );

  modport slave (
    input  addr,
    input  req,
    output s0_sel,
    output s1_sel
  );
endinterface

// File: rtl/bus_addr.sv
// bus_addr
// Address decoder for the two-slave system bus plus a small debug status block.
//   clk          : system clock, status registers update on rising edge
//   reset        : synchronous active-high reset (status registers only)
//   bus          : slave side of bus_addr_if (addr, req in; s0_sel, s1_sel out)
//   err_clr      : clears the sticky unmapped flag on the next rising edge
//   last_sel     : one-hot {s1,s0} of the last qualified transfer, 00 = none/unmapped
//   unmapped_err : sticky flag, a qualified transfer hit no slave
//   s0_hits      : saturating count of qualified slave-0 transfers
//   s1_hits      : saturating count of qualified slave-1 transfers
// Slave 0 owns 0x00-0x1F, slave 1 owns 0x20-0x3F; everything above is unmapped.
module bus_addr #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  bus_addr_if.slave        bus,
  input  logic             err_clr,
  output logic [1:0]       last_sel,
  output logic             unmapped_err,
  output logic [CNT_W-1:0] s0_hits,
  output logic [CNT_W-1:0] s1_hits
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s0_sel;
  logic             s1_sel;

  logic [1:0]       last_sel_d,     last_sel_q;
  logic             unmapped_err_d, unmapped_err_q;
  logic [CNT_W-1:0] s0_hits_d,      s0_hits_q;
  logic [CNT_W-1:0] s1_hits_d,      s1_hits_q;

  // Window decode looks only at the top three address bits; the low five
  // bits are the offset inside a 32-byte window. Purely combinational so the
  // select is valid in the same cycle as the address, with no dependence on
  // clock, reset or req.
  always_comb begin
    s0_sel = 1'b0;
    s1_sel = 1'b0;
    case (bus.addr[7:5])
      3'b000:  s0_sel = 1'b1;
      3'b001:  s1_sel = 1'b1;
      default: ;
    endcase
  end

  assign bus.s0_sel = s0_sel;
  assign bus.s1_sel = s1_sel;

  // Next-state for the status block. Everything holds unless req qualifies a
  // transfer. The clear is applied first so that an unmapped transfer in the
  // same cycle re-sets the flag, i.e. set wins over clear.
  always_comb begin
    last_sel_d     = last_sel_q;
    unmapped_err_d = unmapped_err_q;
    s0_hits_d      = s0_hits_q;
    s1_hits_d      = s1_hits_q;

    if (err_clr) begin
      unmapped_err_d = 1'b0;
    end

    if (bus.req) begin
      last_sel_d = {s1_sel, s0_sel};
      if (s0_sel && (s0_hits_q != CNT_MAX)) begin
        s0_hits_d = s0_hits_q + CNT_ONE;
      end
      if (s1_sel && (s1_hits_q != CNT_MAX)) begin
        s1_hits_d = s1_hits_q + CNT_ONE;
      end
      if (!s0_sel && !s1_sel) begin
        unmapped_err_d = 1'b1;
      end
    end
  end

  // Status registers; reset overrides any transfer or clear in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_sel_q     <= 2'b00;
      unmapped_err_q <= 1'b0;
      s0_hits_q      <= '0;
      s1_hits_q      <= '0;
    end else begin
      last_sel_q     <= last_sel_d;
      unmapped_err_q <= unmapped_err_d;
      s0_hits_q      <= s0_hits_d;
      s1_hits_q      <= s1_hits_d;
    end
  end

  assign last_sel     = last_sel_q;
  assign unmapped_err = unmapped_err_q;
  assign s0_hits      = s0_hits_q;
  assign s1_hits      = s1_hits_q;

endmodule

// File: tb/tb_bus_addr.sv
// tb_bus_addr
// Scoreboard bench for bus_addr with a 2-bit hit counter so saturation is
// reachable quickly. Stimulus pushes hand-computed expectations into a queue;
// a separate monitor pops and compares each time a sample point is signalled.
module tb_bus_addr;

  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             clk_en;
  logic             reset;
  logic             err_clr;
  logic [1:0]       last_sel;
  logic             unmapped_err;
  logic [CNT_W-1:0] s0_hits;
  logic [CNT_W-1:0] s1_hits;

  bus_addr_if bus ();

  bus_addr #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .err_clr      (err_clr),
    .last_sel     (last_sel),
    .unmapped_err (unmapped_err),
    .s0_hits      (s0_hits),
    .s1_hits      (s1_hits)
  );

  typedef struct {
    string      name;
    logic [1:0] exp_sel;
    bit         chk_status;
    logic [1:0] exp_last;
    logic       exp_err;
    logic [1:0] exp_s0;
    logic [1:0] exp_s1;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Clock is held low until the decode-only phase is done, so the first
  // checks show the selects working with no clock edges at all.
  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic cmpVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpVal({e.name, " sel"}, {6'b0, bus.s1_sel, bus.s0_sel}, {6'b0, e.exp_sel});
    if (e.chk_status) begin
      cmpVal({e.name, " last_sel"},     {6'b0, last_sel},     {6'b0, e.exp_last});
      cmpVal({e.name, " unmapped_err"}, {7'b0, unmapped_err}, {7'b0, e.exp_err});
      cmpVal({e.name, " s0_hits"},      {6'b0, s0_hits},      {6'b0, e.exp_s0});
      cmpVal({e.name, " s1_hits"},      {6'b0, s1_hits},      {6'b0, e.exp_s1});
    end
  endtask

  // Monitor: drains every pending expectation at each sample point.
  initial begin
    forever begin
      @(sample_ev);
      while (sb_q.size() != 0) begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic r, input logic clr,
                               input logic rst);
    bus.addr = a;
    bus.req  = r;
    err_clr  = clr;
    reset    = rst;
  endtask

  // Decode-only vector: no clock involved, sampled 1 ns after the change.
  task automatic comboVec(input string name, input logic [7:0] a, input logic [1:0] sel);
    exp_t e;
    applyStimulus(a, 1'b0, 1'b0, 1'b0);
    #1;
    e = '{name: name, exp_sel: sel, chk_status: 1'b0,
          exp_last: 2'b00, exp_err: 1'b0, exp_s0: 2'b00, exp_s1: 2'b00};
    sb_q.push_back(e);
    -> sample_ev;
    #9;
  endtask

  // Clocked vector: inputs applied at the falling edge, status sampled 1 ns
  // after the following rising edge.
  task automatic stepCycle(input string name, input logic [7:0] a, input logic r,
                           input logic clr, input logic rst, input logic [1:0] sel,
                           input logic [1:0] last, input logic err,
                           input logic [1:0] s0, input logic [1:0] s1);
    exp_t e;
    applyStimulus(a, r, clr, rst);
    @(posedge clk);
    #1;
    e = '{name: name, exp_sel: sel, chk_status: 1'b1,
          exp_last: last, exp_err: err, exp_s0: s0, exp_s1: s1};
    sb_q.push_back(e);
    -> sample_ev;
    @(negedge clk);
  endtask

  initial begin
    clk_en = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    #10;

    comboVec("dec_00", 8'h00, 2'b01);
    comboVec("dec_0F", 8'h0F, 2'b01);
    comboVec("dec_20", 8'h20, 2'b10);
    comboVec("dec_2F", 8'h2F, 2'b10);
    comboVec("dec_40", 8'h40, 2'b00);
    comboVec("dec_50", 8'h50, 2'b00);
    comboVec("bnd_1F", 8'h1F, 2'b01);
    comboVec("bnd_20", 8'h20, 2'b10);
    comboVec("bnd_3F", 8'h3F, 2'b10);
    comboVec("bnd_40", 8'h40, 2'b00);
    comboVec("bnd_FF", 8'hFF, 2'b00);

    clk_en = 1'b1;
    @(negedge clk);

    //        name          addr   req   clr   rst   sel    last   err   s0     s1
    stepCycle("rst",        8'h05, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 2'd0, 2'd0);
    stepCycle("cnt_05",     8'h05, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 2'd1, 2'd0);
    stepCycle("cnt_25a",    8'h25, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'd1, 2'd1);
    stepCycle("cnt_25b",    8'h25, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'd1, 2'd2);
    stepCycle("hold",       8'h05, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 2'd1, 2'd2);
    stepCycle("unmap_80",   8'h80, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'd1, 2'd2);
    stepCycle("sticky",     8'h05, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 2'd1, 2'd2);
    stepCycle("clr_alone",  8'h05, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 2'd1, 2'd2);
    stepCycle("unmap_80b",  8'h80, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'd1, 2'd2);
    stepCycle("set_wins",   8'h90, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'd1, 2'd2);
    stepCycle("sat_10_1",   8'h10, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 2'd2, 2'd2);
    stepCycle("sat_10_2",   8'h10, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 2'd3, 2'd2);
    stepCycle("sat_10_3",   8'h10, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 2'd3, 2'd2);
    stepCycle("sat_10_4",   8'h10, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 2'd3, 2'd2);
    stepCycle("sat_10_5",   8'h10, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 2'd3, 2'd2);
    stepCycle("sat_3F_1",   8'h3F, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 2'd3, 2'd3);
    stepCycle("sat_3F_2",   8'h3F, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 2'd3, 2'd3);
    stepCycle("rst_mid",    8'h10, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 2'd0, 2'd0);
    stepCycle("post_rst",   8'h10, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 2'd0, 2'd0);
    stepCycle("after_rst",  8'h30, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'd0, 2'd1);

    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bus_addr.md
# bus_addr

Address decoder for the two-slave system bus. It maps the master's 8-bit address onto one of two 32-byte slave windows and drives one-hot slave selects combinationally, so a bus transfer sees the select in the same cycle. It sits between the bus master's address lines and the slave multiplexer and carries a small clocked status block (last-selected slave, unmapped-access flag, per-slave hit counters) for debug.

## Interface
Parameters:
- CNT_W, 8, width of each per-slave hit counter (saturating).

Ports:
- clk  input  1  system clock; all status registers update on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- addr  input  8  bus address from the master.
- s0_sel  output  1  slave 0 select; combinational.
- s1_sel  output  1  slave 1 select; combinational.
- req  input  1  transfer-valid strobe; only qualifies status updates, never the selects.
- last_sel  output  2  registered one-hot {s1,s0} of the last qualified transfer; 2'b00 means none or unmapped.
- unmapped_err  output  1  sticky flag: a qualified transfer hit no slave.
- err_clr  input  1  clears unmapped_err on the next rising clk.
- s0_hits  output  CNT_W  count of qualified slave-0 transfers.
- s1_hits  output  CNT_W  count of qualified slave-1 transfers.

## Operation
- Decode uses addr[7:5] only; addr[4:0] is the offset inside the window and is ignored.
- addr[7:5] = 3'b000 (0x00–0x1F): s0_sel = 1, s1_sel = 0.
- addr[7:5] = 3'b001 (0x20–0x3F): s0_sel = 0, s1_sel = 1.
- Any other value (0x40–0xFF): both selects 0.
- Selects are mutually exclusive. They depend only on addr and are independent of clk, reset and req.
- A qualified transfer is req = 1 at a rising clk edge.
- On a qualified transfer, last_sel <= {s1_sel, s0_sel}. The matching hit counter increments by 1 and saturates at 2^CNT_W−1; it does not wrap.
- If a qualified transfer selects no slave, unmapped_err <= 1 and last_sel <= 2'b00.
- err_clr = 1 clears unmapped_err. If err_clr is asserted in the same cycle as a new unmapped qualified transfer, the set wins and the flag stays 1.
- With req = 0, all registers hold.

## Timing
- s0_sel and s1_sel have zero-cycle latency and are purely combinational. They must be valid within the same simulation step that addr changes, even if clk never toggles and reset was never applied.
- Status outputs have one-cycle latency: they reflect the qualified transfer at edge N from just after edge N.
- Reset values on the edge where reset = 1:
  - last_sel = 2'b00
  - unmapped_err = 0
  - s0_hits = 0
  - s1_hits = 0
- Reset overrides req and err_clr.
- Reset asserted mid-stream discards that cycle's update.
- Reset never affects s0_sel or s1_sel.

## Test plan
- Combinational decode, no clock: apply addr = 0x00, 0x0F, 0x20, 0x2F, 0x40, 0x50, 10 ns apart. Required {s1_sel, s0_sel} = 01, 01, 10, 10, 00, 00, each valid before the next change.
- Window boundaries: addr = 0x1F → s0_sel = 1; 0x20 → s1_sel = 1; 0x3F → s1_sel = 1; 0x40 → both 0; 0xFF → both 0.
- Status counting: reset, then qualified transfers at 0x05, 0x25, 0x25. Required s0_hits = 1, s1_hits = 2, last_sel = 2'b10 one cycle after the last edge.
- Unmapped flag: a qualified transfer at 0x80 sets unmapped_err = 1 and last_sel = 00. err_clr alone clears it. err_clr together with a transfer at 0x90 keeps it at 1.
- Saturation and reset: with CNT_W = 2, five qualified transfers at 0x10 give s0_hits = 3. Asserting reset with req = 1 gives all status outputs 0 on the next cycle, while s0_sel stays 1.
